// File: rtl/md_pkg.sv
// Shared types and constants for the signed MULT/DIV sequencer behind HI/LO.
package md_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MULT  = 3'd1,
        DIV   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4,
        DZERO = 3'd5
    } md_state_t;

    localparam logic OP_MULT    = 1'b0;
    localparam logic OP_DIV     = 1'b1;
    localparam int   MD_WIDTH   = 32;
    localparam int   ITER_CNT_W = $clog2(MD_WIDTH);

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift in the quotient bit.
module md_div_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;

    // Trial subtraction on the W+1 bit shifted remainder; restore when it goes negative.
    always_comb begin
        shifted_s = {rem_i, quo_i[WIDTH-1]};
        fits_s    = (shifted_s >= {1'b0, divisor_i});
        diff_s    = shifted_s[WIDTH-1:0] - divisor_i;
        if (fits_s) begin
            rem_o = diff_s;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted_s[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multicycle sequencer for the signed MULT/DIV unit feeding HI/LO: operand sign
// handling, iteration control, HI/LO write strobes and divide-by-zero reporting.
module mult_div_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             opDiv,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             writeHI,
    output logic             writeLO,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_q, wr_d;
    logic               dz_q, dz_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic [WIDTH-1:0]   step_quo_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return neg_w(v);
        end else begin
            return v;
        end
    endfunction

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (work_q[WIDTH-1:0]),
        .divisor_i (opb_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Shift-add multiply step: the multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]};
        mul_next_s = work_q;
        if (work_q[0]) begin
            mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
        end else begin
            mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, work_q[WIDTH-1:1]};
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        work_d   = work_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        wr_d     = 1'b0;
        dz_d     = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = opDiv;
                    sign_a_d = srcA[WIDTH-1];
                    sign_b_d = srcB[WIDTH-1];
                    opa_d    = abs_w(srcA);
                    opb_d    = abs_w(srcB);
                    cnt_d    = {CNT_W{1'b0}};
                    rem_d    = {WIDTH{1'b0}};
                    if (opDiv == OP_MULT) begin
                        work_d  = {{WIDTH{1'b0}}, abs_w(srcB)};
                        state_d = MULT;
                    end else if (srcB == {WIDTH{1'b0}}) begin
                        state_d = DZERO;
                    end else begin
                        work_d  = {{WIDTH{1'b0}}, abs_w(srcA)};
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MULT: begin
                work_d = mul_next_s;
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end else begin
                    state_d = MULT;
                end
            end
            DIV: begin
                rem_d  = step_rem_s;
                work_d = {{WIDTH{1'b0}}, step_quo_s};
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end
            FIX: begin
                // Remainder follows the dividend's sign so division truncates toward zero.
                if (op_q == OP_DIV) begin
                    work_d[2*WIDTH-1:WIDTH] = sign_a_q ? neg_w(rem_q) : rem_q;
                    work_d[WIDTH-1:0]       = (sign_a_q ^ sign_b_q) ? neg_w(work_q[WIDTH-1:0])
                                                                    : work_q[WIDTH-1:0];
                end else if (sign_a_q ^ sign_b_q) begin
                    work_d = ~work_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    work_d = work_q;
                end
                state_d = DONE;
            end
            DONE: begin
                hi_d    = work_q[2*WIDTH-1:WIDTH];
                lo_d    = work_q[WIDTH-1:0];
                done_d  = 1'b1;
                wr_d    = 1'b1;
                state_d = IDLE;
            end
            DZERO: begin
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opa_q    <= {WIDTH{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            work_q   <= {(2*WIDTH){1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            dz_q     <= dz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign writeHI = wr_q;
    assign writeLO = wr_q;
    assign hiOut   = hi_q;
    assign loOut   = lo_q;
    assign divZero = dz_q;

endmodule
